auto_correlation_multi: RTL and testbench
=========================================

Name: auto_correlation_multi

Overview:
- Next-generation on-the-fly autocorrelation engine for TRNG health and characterisation.
- Computes match counts for NUM_LAGS consecutive lags in parallel over one sample stream:
  - Lags run from a run-time base lag up to base+NUM_LAGS-1.
  - A single DEPTH-entry delay line serves all lags.
- Adds a sample limit, an explicit state machine and overflow protection.
- Counters are read back through a registered select port and sit behind the register interface.

Parameters:
- WIDTH, 1: sample width in bits.
- DEPTH, 256: maximum supported lag, i.e. number of delay-line entries.
- NUM_LAGS, 8: number of lags computed in parallel.
- LAG_WIDTH, 9: width of the lag base; must hold DEPTH.
- SEL_WIDTH, 3: readout select width; 2^SEL_WIDTH >= NUM_LAGS.
- OUT_WIDTH, 32: counter width.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_init  in  1  one-cycle pulse: clear and start a new run.
- i_lag_base  in  LAG_WIDTH  first lag, latched on i_init; 0 is treated as 1.
- i_limit  in  OUT_WIDTH  sample limit, latched on i_init; 0 = unlimited.
- i_dat  in  WIDTH  sample.
- i_write  in  1  sample valid.
- i_sel  in  SEL_WIDTH  lag channel to read.
- o_write_cnt  out  OUT_WIDTH  samples accepted since i_init.
- o_match_cnt  out  OUT_WIDTH  match count of channel i_sel (registered).
- o_running  out  1  state==RUN.
- o_done  out  1  state==DONE.
- o_full  out  1  o_write_cnt == all-ones.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - All counters, delay line, latched base/limit and o_match_cnt cleared to 0.
  - o_running=o_done=o_full=0.
- States:
  - IDLE -> RUN on i_init.
  - RUN -> DONE when an accepted sample makes o_write_cnt equal the nonzero limit, or makes o_write_cnt all-ones.
  - DONE -> RUN on i_init.
  - i_init in RUN restarts the run: counters cleared, new base and limit latched, stays in RUN.
- Accept rule:
  - A sample is accepted when i_write=1, state==RUN and i_init=0.
  - i_write in IDLE or DONE is ignored: no shift, no count.
  - i_write in the same cycle as i_init is ignored.
- Delay line:
  - On accept, shifts in i_dat.
  - Entry k (1..DEPTH) holds the sample accepted k accepts earlier.
- Channel j (0..NUM_LAGS-1) has lag L_j = base+j.
- On accept of sample number n (n = o_write_cnt before the increment):
  - If L_j <= DEPTH and n >= L_j: compare i_dat with entry L_j; increment match_cnt[j] on equality.
  - Otherwise channel j does not count, including its priming phase.
  - Channels with L_j > DEPTH are disabled and stay 0.
- Latency:
  - Counters and o_write_cnt update on the edge following the accept.
  - o_match_cnt = match_cnt[i_sel] registered: one cycle after an i_sel change or a counter update.
  - i_sel >= NUM_LAGS reads 0.
- Overflow:
  - o_write_cnt never wraps; the state goes to DONE on reaching all-ones.
  - match_cnt <= o_write_cnt always, so match counters never wrap.
- Arithmetic:
  - Lag sum computed in LAG_WIDTH+1 bits, no truncation.
  - Limit compare is a full OUT_WIDTH equality.
- Reset asserted mid-run: immediate clear to IDLE; a subsequent i_init is required.

Optional Feature:
- Macro AUTO_CORRELATION_ONES_CNT_EN.
- When defined:
  - Adds output o_ones_cnt [OUT_WIDTH].
  - Counts total set bits of all accepted samples since i_init, saturating at all-ones.
  - Cleared on reset and on i_init.
  - Updates with the same latency as o_write_cnt.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=1, DEPTH=16, NUM_LAGS=4, SEL_WIDTH=2 unless stated.
1. Alternating stream: init base=1, 100 accepted samples 0,1,0,1,...
   -> o_write_cnt=100; sel0..3 read 0, 98, 0, 96.
2. All-ones stream: init base=3, 20 samples.
   -> lags 3..6 read 17, 16, 15, 14; o_running=1, o_done=0.
3. Sample limit: init base=1, limit=10, 15 writes of 1.
   -> o_done rises the cycle after the 10th accept; o_write_cnt=10; sel0=9; the 5 extra writes change nothing.
4. Overflow, OUT_WIDTH=4: init base=1, limit=0, 20 zeros.
   -> o_write_cnt stops at 15, o_full=1, o_done=1; sel0=14.
5. Disabled channels: init base=14, 30 zeros.
   -> lags 14, 15, 16 read 16, 15, 14; lag 17 reads 0.
6. Init and reset interactions: i_init with i_write in the same cycle -> o_write_cnt=0 afterwards. Assert i_rst_n=0 mid-run, asynchronously mid-cycle -> all outputs 0 before the next edge, state IDLE; writes are ignored until i_init.

Source files
------------

// File: rtl/auto_correlation_multi.sv
// Multi-lag autocorrelation engine: NUM_LAGS match counters over one shared delay line.
// Optional macro AUTO_CORRELATION_ONES_CNT_EN adds a saturating set-bit counter output.
module auto_correlation_multi #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NUM_LAGS  = 8,
  parameter int unsigned LAG_WIDTH = 9,
  parameter int unsigned SEL_WIDTH = 3,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_init,
  input  logic [LAG_WIDTH-1:0] i_lag_base,
  input  logic [OUT_WIDTH-1:0] i_limit,
  input  logic [WIDTH-1:0]     i_dat,
  input  logic                 i_write,
  input  logic [SEL_WIDTH-1:0] i_sel,
  output logic [OUT_WIDTH-1:0] o_write_cnt,
  output logic [OUT_WIDTH-1:0] o_match_cnt,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_full
`ifdef AUTO_CORRELATION_ONES_CNT_EN
  ,
  output logic [OUT_WIDTH-1:0] o_ones_cnt
`endif
);

  localparam int unsigned          CW      = (OUT_WIDTH > LAG_WIDTH + 1) ? OUT_WIDTH : LAG_WIDTH + 1;
  localparam logic [LAG_WIDTH:0]   DEPTH_L = (LAG_WIDTH + 1)'(DEPTH);
  localparam logic [OUT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [LAG_WIDTH-1:0] base_q;
  logic [OUT_WIDTH-1:0] limit_q;
  logic [OUT_WIDTH-1:0] write_cnt;
  logic [OUT_WIDTH-1:0] cnt_inc;
  logic [OUT_WIDTH-1:0] match_cnt [NUM_LAGS];
  logic [OUT_WIDTH-1:0] rd_val;
  logic [WIDTH-1:0]     dline [1:DEPTH];
  logic [WIDTH-1:0]     tap [NUM_LAGS];
  logic [LAG_WIDTH:0]   eff_base;
  logic [LAG_WIDTH:0]   lag [NUM_LAGS];
  logic [NUM_LAGS-1:0]  hit;
  logic                 accept;
  logic                 last_accept;

  assign accept      = i_write && (state == RUN) && !i_init;
  assign cnt_inc     = write_cnt + OUT_WIDTH'(1);
  assign last_accept = accept && (((limit_q != '0) && (cnt_inc == limit_q)) || (cnt_inc == CNT_MAX));
  assign o_write_cnt = write_cnt;

  // Channel j compares against entry base+j only once that many samples exist; lags beyond DEPTH never count.
  always_comb begin
    eff_base = (base_q == '0) ? (LAG_WIDTH + 1)'(1) : {1'b0, base_q};
    hit      = '0;
    for (int unsigned j = 0; j < NUM_LAGS; j++) begin
      lag[j] = eff_base + (LAG_WIDTH + 1)'(j);
      tap[j] = '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (lag[j] == (LAG_WIDTH + 1)'(k)) tap[j] = dline[k];
      end
      hit[j] = (lag[j] <= DEPTH_L) && (CW'(write_cnt) >= CW'(lag[j])) && (tap[j] == i_dat);
    end
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned j = 0; j < NUM_LAGS; j++) begin
      if (i_sel == SEL_WIDTH'(j)) rd_val = match_cnt[j];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_init) state_nx = RUN;
      RUN:     if (i_init) state_nx = RUN;
               else if (last_accept) state_nx = DONE;
      DONE:    if (i_init) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_running = (state == RUN);
    o_done    = (state == DONE);
    o_full    = &write_cnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q    <= '0;
      limit_q   <= '0;
      write_cnt <= '0;
      for (int unsigned j = 0; j < NUM_LAGS; j++) match_cnt[j] <= '0;
    end else if (i_init) begin
      base_q    <= i_lag_base;
      limit_q   <= i_limit;
      write_cnt <= '0;
      for (int unsigned j = 0; j < NUM_LAGS; j++) match_cnt[j] <= '0;
    end else if (accept) begin
      write_cnt <= cnt_inc;
      for (int unsigned j = 0; j < NUM_LAGS; j++) begin
        if (hit[j]) match_cnt[j] <= match_cnt[j] + OUT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 1; k <= DEPTH; k++) dline[k] <= '0;
    end else if (accept) begin
      for (int unsigned k = DEPTH; k > 1; k--) dline[k] <= dline[k-1];
      dline[1] <= i_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_match_cnt <= '0;
    else          o_match_cnt <= rd_val;
  end

`ifdef AUTO_CORRELATION_ONES_CNT_EN
  logic [OUT_WIDTH:0] ones_sum;
  assign ones_sum = {1'b0, o_ones_cnt} + (OUT_WIDTH + 1)'($countones(i_dat));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_ones_cnt <= '0;
    else if (i_init) o_ones_cnt <= '0;
    else if (accept) o_ones_cnt <= ones_sum[OUT_WIDTH] ? '1 : ones_sum[OUT_WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_auto_correlation_multi.sv
// Bench for auto_correlation_multi: history-queue model checked every cycle plus literal expectations.
module tb_auto_correlation_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init, write;
  logic [4:0]  lag_base;
  logic [31:0] limit;
  logic [0:0]  dat;
  logic [1:0]  sel;
  logic [31:0] wcnt, mcnt_o;
  logic        running, done, full;

  logic        s_init, s_write;
  logic [3:0]  s_limit;
  logic [0:0]  s_dat;
  logic [1:0]  s_sel;
  logic [3:0]  s_wcnt, s_mcnt;
  logic        s_running, s_done, s_full;
`ifdef AUTO_CORRELATION_ONES_CNT_EN
  logic [31:0] ones;
  logic [3:0]  s_ones;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  auto_correlation_multi #(.WIDTH(1), .DEPTH(16), .NUM_LAGS(4), .LAG_WIDTH(5), .SEL_WIDTH(2), .OUT_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_lag_base(lag_base), .i_limit(limit),
    .i_dat(dat), .i_write(write), .i_sel(sel), .o_write_cnt(wcnt), .o_match_cnt(mcnt_o),
    .o_running(running), .o_done(done), .o_full(full)
`ifdef AUTO_CORRELATION_ONES_CNT_EN
    , .o_ones_cnt(ones)
`endif
  );

  auto_correlation_multi #(.WIDTH(1), .DEPTH(16), .NUM_LAGS(4), .LAG_WIDTH(5), .SEL_WIDTH(2), .OUT_WIDTH(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(s_init), .i_lag_base(lag_base), .i_limit(s_limit),
    .i_dat(s_dat), .i_write(s_write), .i_sel(s_sel), .o_write_cnt(s_wcnt), .o_match_cnt(s_mcnt),
    .o_running(s_running), .o_done(s_done), .o_full(s_full)
`ifdef AUTO_CORRELATION_ONES_CNT_EN
    , .o_ones_cnt(s_ones)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: keeps the full accepted-sample history and counts matches against it.
  bit          m_run, m_done;
  int          m_base;
  logic [31:0] m_limit, m_wcnt, m_rd, m_ones;
  logic [31:0] m_mcnt [4];
  bit          hist [$];

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nxt_rd;
    int          n, lg;
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_base = 1; m_limit = 0; m_wcnt = 0; m_rd = 0; m_ones = 0;
      for (int j = 0; j < 4; j++) m_mcnt[j] = 0;
      hist.delete();
    end else begin
      nxt_rd = m_mcnt[sel];
      if (init) begin
        m_run = 1; m_done = 0; m_wcnt = 0; m_ones = 0;
        for (int j = 0; j < 4; j++) m_mcnt[j] = 0;
        hist.delete();
        m_base  = (lag_base == 0) ? 1 : int'(lag_base);
        m_limit = limit;
      end else if (write && m_run) begin
        n = int'(m_wcnt);
        for (int j = 0; j < 4; j++) begin
          lg = m_base + j;
          if (lg <= 16 && n >= lg && hist[n - lg] == dat[0]) m_mcnt[j] = m_mcnt[j] + 1;
        end
        hist.push_back(dat[0]);
        m_wcnt = m_wcnt + 1;
        if (dat[0]) m_ones = m_ones + 1;
        if ((m_limit != 0 && m_wcnt == m_limit) || m_wcnt == 32'hFFFF_FFFF) begin
          m_run = 0; m_done = 1;
        end
      end
      m_rd = nxt_rd;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && chk_en) begin
      chk("model_write_cnt", wcnt, m_wcnt);
      chk("model_match_cnt", mcnt_o, m_rd);
      chk("model_running", 32'(running), 32'(m_run));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_full", 32'(full), 32'(m_wcnt == 32'hFFFF_FFFF));
`ifdef AUTO_CORRELATION_ONES_CNT_EN
      chk("model_ones_cnt", ones, m_ones);
`endif
    end
  end

  task automatic cyc(input bit in, input bit wr, input bit d);
    init = in; write = wr; dat = d;
    @(posedge clk); #1;
    init = 1'b0; write = 1'b0;
  endtask

  task automatic start(input logic [4:0] b, input logic [31:0] lim);
    lag_base = b; limit = lim;
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] s, input logic [31:0] exp, input string name);
    sel = s;
    @(posedge clk); @(negedge clk);
    chk(name, mcnt_o, exp);
  endtask

  initial begin
    rst_n = 1'b0; init = 0; write = 0; dat = 0; sel = 0; lag_base = 0; limit = 0;
    s_init = 0; s_write = 0; s_dat = 0; s_sel = 0; s_limit = 0;
    #12;
    chk("reset_write_cnt", wcnt, 0);
    chk("reset_match_cnt", mcnt_o, 0);
    chk("reset_flags", {29'd0, running, done, full}, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: alternating stream, lags 1..4
    start(5'd1, 0);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, bit'(i & 1));
    chk("alt_write_cnt", wcnt, 100);
    rd(2'd0, 0, "alt_lag1"); rd(2'd1, 98, "alt_lag2");
    rd(2'd2, 0, "alt_lag3"); rd(2'd3, 96, "alt_lag4");

    // 2: all ones, lags 3..6
    start(5'd3, 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);
    rd(2'd0, 17, "ones_lag3"); rd(2'd1, 16, "ones_lag4");
    rd(2'd2, 15, "ones_lag5"); rd(2'd3, 14, "ones_lag6");
    chk("ones_running", 32'(running), 1);
    chk("ones_done", 32'(done), 0);

    // 3: sample limit of 10
    start(5'd1, 10);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("limit_not_done_at9", 32'(done), 0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("limit_done_at10", 32'(done), 1);
    chk("limit_write_cnt10", wcnt, 10);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("limit_write_cnt_after", wcnt, 10);
    rd(2'd0, 9, "limit_lag1");

    // 4: overflow on the 4-bit counter instance
    s_init = 1'b1; lag_base = 5'd1; s_limit = 0;
    @(posedge clk); #1; s_init = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_write = 1'b1; s_dat = 1'b0;
      @(posedge clk); #1;
    end
    s_write = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ovf_write_cnt", 32'(s_wcnt), 15);
    chk("ovf_full", 32'(s_full), 1);
    chk("ovf_done", 32'(s_done), 1);
    chk("ovf_running", 32'(s_running), 0);
    chk("ovf_lag1", 32'(s_mcnt), 14);

    // 5: base 14, lag 17 exceeds depth
    start(5'd14, 0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0);
    rd(2'd0, 16, "dis_lag14"); rd(2'd1, 15, "dis_lag15");
    rd(2'd2, 14, "dis_lag16"); rd(2'd3, 0, "dis_lag17");

    // 6: init+write same cycle, async reset mid-run
    start(5'd1, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("init_write_ignored", wcnt, 0);
    sel = 2'd0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_write_cnt", wcnt, 0);
    chk("rst_match_cnt", mcnt_o, 0);
    chk("rst_flags", {29'd0, running, done, full}, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("idle_write_ignored", wcnt, 0);
    chk("idle_not_running", 32'(running), 0);
    start(5'd2, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("restart_write_cnt", wcnt, 4);
    rd(2'd0, 2, "restart_lag2");

    @(posedge clk); @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
